cabac_ctx_pair_serializer: RTL
==============================

// Module: cabac_ctx_pair_serializer
// PURPOSE
//  Ping-pong buffer and serializer downstream of the CU intra/inter binarizers.
//  - Accepts one group of up to 11 ctx pairs, plus a valid count, in one cycle.
//  - Emits the pairs one per cycle, index 0 first, to the BAE/ctx-model stage over a valid/ready handshake.
//  - Two banks let the binarizer load group N+1 while group N drains.
// PARAMETERS
//  PAIR_W     11  ctx pair width: {coding_mode[1:0], bin/rsvd, bank/num[2:0], addr/bins[4:0]}
//  MAX_PAIRS  11  pairs per group
//  CNT_W      5   width of the valid-count field
// PORTS
//  clk              in   1                  clock; all logic is rising-edge
//  rst_n            in   1                  synchronous reset, active-low
//  group_valid_i    in   1                  a group is presented on ctx_pairs_i / ctx_valid_num_i
//  group_ready_o    in/out: out  1          write bank is free; group accepted when valid && ready
//  ctx_pairs_i      in   MAX_PAIRS*PAIR_W   pair k on bits [k*PAIR_W +: PAIR_W]; pair 0 at the LSBs
//  ctx_valid_num_i  in   CNT_W              number of valid pairs, indices 0..num-1
//  pair_valid_o     out  1                  pair_o holds a valid pair
//  pair_ready_i     in   1                  consumer accepts pair_o this cycle
//  pair_o           out  PAIR_W             current ctx pair, forwarded verbatim
//  pair_last_o      out  1                  pair_o is the last pair of its group
//  busy_o           out  1                  at least one bank is full
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge):
//    - both banks empty; wr_bank=0, rd_bank=0, rd_idx=0
//    - pair_valid_o=0, pair_last_o=0, pair_o=0, busy_o=0
//    - group_ready_o=1 from the first cycle after reset
//    - reset mid-drain discards all buffered pairs; no partial group resumes
//  - Load:
//    - group_ready_o = !full[wr_bank], decoded from registers only; there is no comb path from pair_ready_i
//    - on accept: store all MAX_PAIRS pairs and num into bank[wr_bank], set full, toggle wr_bank
//    - num > MAX_PAIRS is clamped to MAX_PAIRS
//    - num == 0: group is accepted and dropped; bank stays empty, wr_bank does not toggle
//  - Drain:
//    - pair_valid_o = full[rd_bank]
//    - pair_o = bank[rd_bank].pair[rd_idx]
//    - pair_last_o = pair_valid_o && (rd_idx == num-1)
//    - entries at index >= num are never emitted; mode-01 padding beyond num is ignored
//    - on pair_valid_o && pair_ready_i:
//      - if last: clear full[rd_bank], toggle rd_bank, rd_idx=0
//      - else: rd_idx++
//    - while valid && !ready: pair_o and pair_last_o hold stable
//  - Latency: group accepted at edge N -> first pair valid in cycle N+1 when the read bank was empty. Throughput is 1 pair/cycle, with no bubble between groups when the other bank is full.
//  - Simultaneous accept and free on the same bank: impossible by design, because ready uses the pre-edge full flag. A bank freed at edge N accepts a group at edge N+1 at the earliest.
//  - Simultaneous accept (write bank) and drain (read bank) on different banks are fully independent.
//  - Both banks full: group_ready_o=0; the binarizer must hold its inputs.
//  - busy_o = full[0] | full[1]
// STRUCTURE
//  - Shared `defines in enc_defines.v:
//    - coding-mode codes: REGULAR=2'b00, INVALID=2'b01, BYPASS=2'b10, TERMINAL=2'b11
//    - PAIR_W, MAX_PAIRS
//  - Sub-module cabac_ctx_pair_bank, instanced twice. It holds:
//    - the pair registers and num
//    - the full flag, with load/free strobes
//    - a read mux indexed by rd_idx
//  - Top level holds wr_bank, rd_bank, rd_idx and the handshake logic.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles then 1.
//     -> group_ready_o=1, pair_valid_o=0, busy_o=0.
//  2. Single group, num=5, pairs 0x100..0x104, pair_ready_i=1.
//     -> cycles N+1..N+5 emit 0x100..0x104; last=1 only on 0x104; then valid=0.
//  3. Back-to-back groups, num=11 then num=5, ready=1.
//     -> 16 consecutive valid cycles with no bubble.
//     -> group_ready_o drops low during the 3rd load attempt until the first bank frees.
//  4. Backpressure: num=3, ready toggles 1,0,0,1,1.
//     -> pair_o holds during the 0 cycles; exactly 3 pairs are transferred, in order.
//  5. num=0, then num=31.
//     -> the num=0 group is accepted with no output.
//     -> the num=31 group emits exactly 11 pairs, last on index 10.
//  6. Reset asserted after 2 of 11 pairs have drained.
//     -> next cycle valid=0 and busy=0; a new group num=1 emits exactly 1 pair.

Source files
------------

// File: rtl/cabac_ctx_pair_serializer_pkg.sv
// Shared constants for the CABAC ctx pair serializer: geometry of a pair group
// and the coding-mode codes carried in the top two bits of each pair.
package cabac_ctx_pair_serializer_pkg;

  localparam int DEF_PAIR_W    = 11;
  localparam int DEF_MAX_PAIRS = 11;
  localparam int DEF_CNT_W     = 5;

  typedef enum logic [1:0] {
    MODE_REGULAR  = 2'b00,
    MODE_INVALID  = 2'b01,
    MODE_BYPASS   = 2'b10,
    MODE_TERMINAL = 2'b11
  } coding_mode_e;

endpackage

// File: rtl/cabac_ctx_pair_serializer_bank.sv
// One buffer bank: a full group of ctx pairs, its clamped valid count and a
// full flag, with a read mux selected by the drain index.
module cabac_ctx_pair_serializer_bank
  import cabac_ctx_pair_serializer_pkg::*;
#(
  parameter int PAIR_W    = DEF_PAIR_W,
  parameter int MAX_PAIRS = DEF_MAX_PAIRS,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int IDX_W     = $clog2(MAX_PAIRS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic                        free,
  input  logic [MAX_PAIRS*PAIR_W-1:0] pairs,
  input  logic [CNT_W-1:0]            num_in,
  input  logic [IDX_W-1:0]            rd_idx,
  output logic                        full,
  output logic [PAIR_W-1:0]           pair,
  output logic [CNT_W-1:0]            num
);

  logic [PAIR_W-1:0] mem [MAX_PAIRS];

  // The top level never raises load and free together on the same bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
      num  <= '0;
      for (int k = 0; k < MAX_PAIRS; k++) mem[k] <= '0;
    end else if (load) begin
      full <= 1'b1;
      num  <= num_in;
      for (int k = 0; k < MAX_PAIRS; k++) mem[k] <= pairs[k*PAIR_W +: PAIR_W];
    end else if (free) begin
      full <= 1'b0;
    end
  end

  always_comb begin
    pair = '0;
    if (rd_idx < IDX_W'(MAX_PAIRS)) pair = mem[rd_idx];
  end

endmodule

// File: rtl/cabac_ctx_pair_serializer.sv
// Ping-pong buffer between the CU binarizers and the BAE/ctx-model stage:
// one bank loads a whole group while the other drains it one pair per cycle.
module cabac_ctx_pair_serializer
  import cabac_ctx_pair_serializer_pkg::*;
#(
  parameter int PAIR_W    = DEF_PAIR_W,
  parameter int MAX_PAIRS = DEF_MAX_PAIRS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        group_valid_i,
  output logic                        group_ready_o,
  input  logic [MAX_PAIRS*PAIR_W-1:0] ctx_pairs_i,
  input  logic [CNT_W-1:0]            ctx_valid_num_i,
  output logic                        pair_valid_o,
  input  logic                        pair_ready_i,
  output logic [PAIR_W-1:0]           pair_o,
  output logic                        pair_last_o,
  output logic                        busy_o
);

  localparam int IDX_W = $clog2(MAX_PAIRS);

  logic              wr_bank;
  logic              rd_bank;
  logic [IDX_W-1:0]  rd_idx;
  logic [1:0]        full;
  logic [1:0]        load;
  logic [1:0]        free;
  logic [PAIR_W-1:0] bank_pair [2];
  logic [CNT_W-1:0]  bank_num  [2];
  logic [CNT_W-1:0]  num_clamped;
  logic [CNT_W-1:0]  cur_num;
  logic              accept;
  logic              store;
  logic              fire;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    cabac_ctx_pair_serializer_bank #(
      .PAIR_W    (PAIR_W),
      .MAX_PAIRS (MAX_PAIRS),
      .CNT_W     (CNT_W),
      .IDX_W     (IDX_W)
    ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load[b]),
      .free   (free[b]),
      .pairs  (ctx_pairs_i),
      .num_in (num_clamped),
      .rd_idx (rd_idx),
      .full   (full[b]),
      .pair   (bank_pair[b]),
      .num    (bank_num[b])
    );
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Valid never depends on ready; ready on the group side comes only from the
  // pre-edge full flag, so a bank freed at one edge can reload at the next.
  assign num_clamped   = (ctx_valid_num_i > CNT_W'(MAX_PAIRS)) ? CNT_W'(MAX_PAIRS)
                                                               : ctx_valid_num_i;
  assign group_ready_o = !full[wr_bank];
  assign accept        = group_valid_i && group_ready_o;
  // An empty group is consumed without occupying a bank.
  assign store         = accept && (num_clamped != '0);
  assign load          = store ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;

  assign cur_num       = bank_num[rd_bank];
  assign pair_valid_o  = full[rd_bank];
  assign pair_o        = bank_pair[rd_bank];
  assign pair_last_o   = pair_valid_o && (CNT_W'(rd_idx) == cur_num - CNT_W'(1));
  assign fire          = pair_valid_o && pair_ready_i;
  assign free          = (fire && pair_last_o) ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
  assign busy_o        = full[0] | full[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      rd_idx  <= '0;
    end else begin
      if (store) wr_bank <= ~wr_bank;
      if (fire) begin
        if (pair_last_o) begin
          rd_bank <= ~rd_bank;
          rd_idx  <= '0;
        end else begin
          rd_idx <= rd_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule
